ftb_assoc_bank: RTL
===================

// Module: ftb_assoc_bank
// PURPOSE
//  Parametrised set-associative FTB bank: next generation of the single-entry ftbInfo_t storage.
//  - Lookup: given a fetch-block start PC, returns hit, predicted taken (2-bit counter),
//    fallthru, target and next PC one cycle later.
//  - Update: accepts resolved-branch updates from the FTQ through a valid/ready handshake and
//    performs read-modify-write with per-set round-robin replacement.
//  - Generalises target encoding from a fixed +/-1 window to a configurable upper-window range.
//  - Sits between the uBTB (stage 0) and the FTQ (stage 2) in the frontend predictor pipeline.
// PARAMETERS
//  XLEN           64  address width
//  SETS           64  number of sets, power of 2
//  WAYS           4   ways per set, power of 2, >=2
//  TAG_WIDTH      16  tag bits taken from pc[$clog2(SETS)+TAG_WIDTH:$clog2(SETS)+1]
//  FALLTHRU_WIDTH 4   stored fallthru offset bits (pc[FALLTHRU_WIDTH:1]) plus carry bit
//  TARGET_WIDTH   12  stored target low bits (pc[TARGET_WIDTH:1])
//  TAR_RANGE      1   max |delta| of upper target bits encodable (1 == FIT/OVF/UDF)
// PORTS
//  clk                 in   1    clock
//  rst                 in   1    asynchronous reset, active high
//  i_flush             in   1    invalidate all entries, abort pending update
//  i_lookup_vld        in   1    lookup request
//  i_lookup_pc         in   XLEN fetch-block start address
//  o_lookup_vld        out  1    lookup result valid (i_lookup_vld delayed 1 cycle)
//  o_hit               out  1    tag match on a valid way
//  o_taken             out  1    counter[1] of hit way; 0 on miss
//  o_fallthru          out  XLEN decoded fallthru; pc_q+2*FTB_PREDICT_WIDTH on miss
//  o_target            out  XLEN decoded target; 0 on miss
//  o_next              out  XLEN o_taken ? o_target : o_fallthru
//  o_branch_type       out  BranchType::_ branch type of hit way
//  i_update_vld        in   1    update request
//  o_update_rdy        out  1    bank can accept update (IDLE and !i_flush)
//  i_update_start      in   XLEN block start
//  i_update_fallthru   in   XLEN resolved fallthru
//  i_update_target     in   XLEN resolved target
//  i_update_btype      in   BranchType::_ branch type
//  i_update_taken      in   1    resolved direction
//  o_update_drop       out  1    1-cycle pulse: update discarded (unencodable fallthru/target)
// BEHAVIOUR
//  - Reset: all valid=0, RR pointers=0, FSM=IDLE, all outputs 0; o_update_rdy=1 after reset release.
//  - Storage in flops. Entry fields: valid, tag, carry, fallthru, tarDelta (signed, TAR_RANGE),
//    target, btype, ctr[1:0].
//  - Lookup: index/tag from i_lookup_pc; compare registered; 1-cycle latency; fully pipelined,
//    1 request/cycle.
//  - Multiple-way hit is a bug: SVA asserts onehot0; lowest way is selected.
//  - Decode: fallthru = {pc_hi+carry, fallthru, 1'b0}; target = {pc_hi+tarDelta, target, 1'b0};
//    upper-part arithmetic wraps mod 2^width.
//  - Update FSM: IDLE -(vld&rdy)-> RD (latch request, read set) -> WR (write entry, advance RR) -> IDLE.
//    3 cycles per update; rdy=0 in RD/WR.
//  - Encoding is checked in RD:
//    - fallthru upper delta must be in {0,1}; target upper delta must be in [-TAR_RANGE,TAR_RANGE].
//    - Otherwise no write, o_update_drop pulses in the WR cycle, RR pointer unchanged.
//  - Hit on update: overwrite fields, ctr = sat(ctr +/-1) in [0,3].
//  - Miss on update: lowest invalid way, else way RR[set]; new ctr = taken ? 2 : 1.
//  - Lookup/update write to same set in same cycle: lookup sees pre-write contents (no bypass).
//  - i_flush: next cycle all valid=0, FSM=IDLE, pending update lost with no drop pulse.
//    o_lookup_vld for an in-flight lookup still asserts, with o_hit=0.
//  - rst mid-update: FSM returns to IDLE immediately, no write.
// TESTING
//  1. After reset, lookup pc=0x1000 -> next cycle o_lookup_vld=1, o_hit=0, o_taken=0, o_fallthru=0x1000+2*FTB_PREDICT_WIDTH.
//  2. Update start=0x1000 ft=0x1008 tgt=0x1040 taken=1, then lookup 0x1000 -> hit, taken=1, o_next=0x1040.
//     Second update taken=0 -> ctr 2->1, o_next=0x1008.
//  3. WAYS+1 distinct tags, same set, all taken -> first-allocated way evicted; lookup of first tag misses, others hit.
//  4. Target 0x1000+(1<<(TARGET_WIDTH+1))*(TAR_RANGE+1) -> o_update_drop=1 one cycle, next lookup still misses.
//     Target at exactly +TAR_RANGE window -> stored and decoded exactly.
//  5. Update in RD/WR with i_update_vld held -> o_update_rdy=0 for 2 cycles, request accepted only in IDLE.
//     Back-to-back lookups each cycle -> all return with 1-cycle latency.
//  6. i_flush one cycle after update accept -> no write, all lookups miss; async rst mid-WR -> outputs 0 at once.

Source files
------------

// File: rtl/ftb_assoc_bank.sv
// ----------------------------------------------------------------------------
// ftb_assoc_bank
//   Set-associative fetch-target-buffer bank. Lookups index a set with the
//   fetch-block start PC and return hit / direction / fallthru / target /
//   next-PC one cycle later, one request per cycle. Resolved-branch updates
//   arrive over a valid/ready handshake and are applied by a three-cycle
//   read-modify-write sequence with per-set round-robin replacement.
//   Fallthru and target are stored compressed: low PC bits plus a small delta
//   on the upper bits relative to the block start.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   i_flush             invalidate every entry, abandon a pending update
//   i_lookup_vld/_pc    lookup request and fetch-block start address
//   o_lookup_vld        lookup result valid (request delayed one cycle)
//   o_hit, o_taken      tag hit, predicted direction (counter msb)
//   o_fallthru/_target  decoded addresses (miss: pc+2*FTB_PREDICT_WIDTH / 0)
//   o_next              o_taken ? o_target : o_fallthru
//   o_branch_type       stored branch type of the hit way
//   i_update_*          update request: start, fallthru, target, type, taken
//   o_update_rdy        update accepted when high (idle, no flush)
//   o_update_drop       one-cycle pulse when an update cannot be encoded
//
// Update FSM
//   state  | meaning
//   S_IDLE | waiting for an update, ready high
//   S_RD   | request latched; set read, way chosen, encoding checked
//   S_WR   | entry written and RR advanced, or drop pulsed
// ----------------------------------------------------------------------------
module ftb_assoc_bank #(
   parameter int XLEN              = 64,
   parameter int SETS              = 64,
   parameter int WAYS              = 4,
   parameter int TAG_WIDTH         = 16,
   parameter int FALLTHRU_WIDTH    = 4,
   parameter int TARGET_WIDTH      = 12,
   parameter int TAR_RANGE         = 1,
   parameter int FTB_PREDICT_WIDTH = 16,
   parameter int BTYPE_WIDTH       = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_flush,
   input  logic                   i_lookup_vld,
   input  logic [XLEN-1:0]        i_lookup_pc,
   output logic                   o_lookup_vld,
   output logic                   o_hit,
   output logic                   o_taken,
   output logic [XLEN-1:0]        o_fallthru,
   output logic [XLEN-1:0]        o_target,
   output logic [XLEN-1:0]        o_next,
   output logic [BTYPE_WIDTH-1:0] o_branch_type,
   input  logic                   i_update_vld,
   output logic                   o_update_rdy,
   input  logic [XLEN-1:0]        i_update_start,
   input  logic [XLEN-1:0]        i_update_fallthru,
   input  logic [XLEN-1:0]        i_update_target,
   input  logic [BTYPE_WIDTH-1:0] i_update_btype,
   input  logic                   i_update_taken,
   output logic                   o_update_drop
);

   localparam int IDX_W = $clog2(SETS);
   localparam int WAY_W = $clog2(WAYS);
   localparam int TD_W  = $clog2(TAR_RANGE + 1) + 1;
   localparam int FHI_W = XLEN - FALLTHRU_WIDTH - 1;
   localparam int THI_W = XLEN - TARGET_WIDTH - 1;

   localparam logic [XLEN-1:0]         MISS_STEP = XLEN'(2 * FTB_PREDICT_WIDTH);
   localparam logic signed [THI_W-1:0] TR_POS    = THI_W'(TAR_RANGE);
   localparam logic signed [THI_W-1:0] TR_NEG    = THI_W'(-TAR_RANGE);

   typedef struct packed {
      logic                      valid;
      logic [TAG_WIDTH-1:0]      tag;
      logic                      carry;
      logic [FALLTHRU_WIDTH-1:0] fallthru;
      logic [TD_W-1:0]           tar_delta;
      logic [TARGET_WIDTH-1:0]   target;
      logic [BTYPE_WIDTH-1:0]    btype;
      logic [1:0]                ctr;
   } entry_t;

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

   entry_t             mem_q [SETS][WAYS];
   logic [WAY_W-1:0]   rr_q  [SETS];

   // ---------------------------------------------------------------- lookup
   logic [IDX_W-1:0]       lk_idx;
   logic [TAG_WIDTH-1:0]   lk_tag;
   logic [WAYS-1:0]        lk_match;
   logic [WAY_W-1:0]       lk_way;
   logic                   lk_hit_d;
   logic [FHI_W-1:0]       lk_ft_hi;
   logic [THI_W-1:0]       lk_tg_hi;
   logic [TD_W-1:0]        lk_td;
   logic                   lk_taken_d;
   logic [XLEN-1:0]        lk_ft_d;
   logic [XLEN-1:0]        lk_tgt_d;
   logic [XLEN-1:0]        lk_next_d;
   logic [BTYPE_WIDTH-1:0] lk_bt_d;

   always_comb begin
      lk_idx   = i_lookup_pc[IDX_W:1];
      lk_tag   = i_lookup_pc[IDX_W+TAG_WIDTH:IDX_W+1];
      lk_match = '0;
      for (int w = 0; w < WAYS; w++)
         lk_match[w] = mem_q[lk_idx][w].valid && (mem_q[lk_idx][w].tag == lk_tag);
      // lowest matching way wins if the onehot0 invariant is ever broken
      lk_way = '0;
      for (int w = WAYS - 1; w >= 0; w--)
         if (lk_match[w]) lk_way = WAY_W'(w);
      // a lookup racing a flush reports a miss
      lk_hit_d = (|lk_match) && !i_flush;
      lk_td    = mem_q[lk_idx][lk_way].tar_delta;
      lk_ft_hi = i_lookup_pc[XLEN-1:FALLTHRU_WIDTH+1] + FHI_W'(mem_q[lk_idx][lk_way].carry);
      lk_tg_hi = i_lookup_pc[XLEN-1:TARGET_WIDTH+1] + {{(THI_W-TD_W){lk_td[TD_W-1]}}, lk_td};
      if (lk_hit_d) begin
         lk_ft_d    = {lk_ft_hi, mem_q[lk_idx][lk_way].fallthru, 1'b0};
         lk_tgt_d   = {lk_tg_hi, mem_q[lk_idx][lk_way].target, 1'b0};
         lk_taken_d = mem_q[lk_idx][lk_way].ctr[1];
         lk_bt_d    = mem_q[lk_idx][lk_way].btype;
      end else begin
         lk_ft_d    = i_lookup_pc + MISS_STEP;
         lk_tgt_d   = '0;
         lk_taken_d = 1'b0;
         lk_bt_d    = '0;
      end
      lk_next_d = lk_taken_d ? lk_tgt_d : lk_ft_d;
   end

   logic                   lk_vld_q, hit_q, taken_q;
   logic [XLEN-1:0]        ft_q, tgt_q, next_q;
   logic [BTYPE_WIDTH-1:0] bt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lk_vld_q <= 1'b0;
         hit_q    <= 1'b0;
         taken_q  <= 1'b0;
         ft_q     <= '0;
         tgt_q    <= '0;
         next_q   <= '0;
         bt_q     <= '0;
      end else begin
         lk_vld_q <= i_lookup_vld;
         if (i_lookup_vld) begin
            hit_q   <= lk_hit_d;
            taken_q <= lk_taken_d;
            ft_q    <= lk_ft_d;
            tgt_q   <= lk_tgt_d;
            next_q  <= lk_next_d;
            bt_q    <= lk_bt_d;
         end
      end
   end

   assign o_lookup_vld  = lk_vld_q;
   assign o_hit         = hit_q;
   assign o_taken       = taken_q;
   assign o_fallthru    = ft_q;
   assign o_target      = tgt_q;
   assign o_next        = next_q;
   assign o_branch_type = bt_q;

   // ---------------------------------------------------------------- update
   state_t                 state_q;
   logic [XLEN-1:0]        req_start_q, req_ft_q, req_tgt_q;
   logic [BTYPE_WIDTH-1:0] req_bt_q;
   logic                   req_taken_q;
   logic                   wr_ok_q;
   logic [WAY_W-1:0]       wr_way_q;
   entry_t                 wr_entry_q;
   logic                   drop_q;

   logic [IDX_W-1:0]     up_idx;
   logic [TAG_WIDTH-1:0] up_tag;
   logic [WAYS-1:0]      up_match;
   logic                 up_hit, up_inv_any;
   logic [WAY_W-1:0]     up_hit_way, up_inv_way, up_way_d;
   logic [FHI_W-1:0]     up_ft_delta;
   logic [THI_W-1:0]     up_tg_delta;
   logic                 up_ok_d;
   logic [1:0]           up_old_ctr, up_ctr_d;
   entry_t               up_entry_d;

   always_comb begin
      up_idx     = req_start_q[IDX_W:1];
      up_tag     = req_start_q[IDX_W+TAG_WIDTH:IDX_W+1];
      up_match   = '0;
      up_hit_way = '0;
      up_inv_way = '0;
      up_inv_any = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         up_match[w] = mem_q[up_idx][w].valid && (mem_q[up_idx][w].tag == up_tag);
         if (!mem_q[up_idx][w].valid) up_inv_any = 1'b1;
      end
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (up_match[w])              up_hit_way = WAY_W'(w);
         if (!mem_q[up_idx][w].valid)  up_inv_way = WAY_W'(w);
      end
      up_hit   = |up_match;
      up_way_d = up_hit ? up_hit_way : (up_inv_any ? up_inv_way : rr_q[up_idx]);

      // deltas wrap modulo the upper-field width, matching the decode adders
      up_ft_delta = req_ft_q[XLEN-1:FALLTHRU_WIDTH+1] - req_start_q[XLEN-1:FALLTHRU_WIDTH+1];
      up_tg_delta = req_tgt_q[XLEN-1:TARGET_WIDTH+1] - req_start_q[XLEN-1:TARGET_WIDTH+1];
      // decode always produces halfword-aligned addresses, so odd ones cannot be stored
      up_ok_d = (up_ft_delta <= FHI_W'(1))
             && ($signed(up_tg_delta) >= TR_NEG) && ($signed(up_tg_delta) <= TR_POS)
             && !req_start_q[0] && !req_ft_q[0] && !req_tgt_q[0];

      up_old_ctr = mem_q[up_idx][up_hit_way].ctr;
      if (up_hit) begin
         if (req_taken_q) up_ctr_d = (up_old_ctr == 2'd3) ? 2'd3 : up_old_ctr + 2'd1;
         else             up_ctr_d = (up_old_ctr == 2'd0) ? 2'd0 : up_old_ctr - 2'd1;
      end else begin
         up_ctr_d = req_taken_q ? 2'd2 : 2'd1;
      end

      up_entry_d           = '0;
      up_entry_d.valid     = 1'b1;
      up_entry_d.tag       = up_tag;
      up_entry_d.carry     = up_ft_delta[0];
      up_entry_d.fallthru  = req_ft_q[FALLTHRU_WIDTH:1];
      up_entry_d.tar_delta = up_tg_delta[TD_W-1:0];
      up_entry_d.target    = req_tgt_q[TARGET_WIDTH:1];
      up_entry_d.btype     = req_bt_q;
      up_entry_d.ctr       = up_ctr_d;
   end

   assign o_update_rdy  = (state_q == S_IDLE) && !i_flush && !rst;
   assign o_update_drop = drop_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         req_start_q <= '0;
         req_ft_q    <= '0;
         req_tgt_q   <= '0;
         req_bt_q    <= '0;
         req_taken_q <= 1'b0;
         wr_ok_q     <= 1'b0;
         wr_way_q    <= '0;
         wr_entry_q  <= '0;
         drop_q      <= 1'b0;
      end else if (i_flush) begin
         state_q <= S_IDLE;
         wr_ok_q <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               drop_q <= 1'b0;
               if (i_update_vld) begin
                  req_start_q <= i_update_start;
                  req_ft_q    <= i_update_fallthru;
                  req_tgt_q   <= i_update_target;
                  req_bt_q    <= i_update_btype;
                  req_taken_q <= i_update_taken;
                  state_q     <= S_RD;
               end
            end
            S_RD: begin
               wr_ok_q    <= up_ok_d;
               wr_way_q   <= up_way_d;
               wr_entry_q <= up_entry_d;
               drop_q     <= !up_ok_d;
               state_q    <= S_WR;
            end
            S_WR: begin
               wr_ok_q <= 1'b0;
               drop_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // storage and RR pointers; lookups in the write cycle read the old contents
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) begin
            rr_q[s] <= '0;
            for (int w = 0; w < WAYS; w++) mem_q[s][w] <= '0;
         end
      end else if (i_flush) begin
         for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) mem_q[s][w].valid <= 1'b0;
      end else if ((state_q == S_WR) && wr_ok_q) begin
         mem_q[up_idx][wr_way_q] <= wr_entry_q;
         rr_q[up_idx]            <= rr_q[up_idx] + WAY_W'(1);
      end
   end

   a_lookup_onehot: assert property (@(posedge clk) disable iff (rst)
      i_lookup_vld |-> $onehot0(lk_match));
   a_update_onehot: assert property (@(posedge clk) disable iff (rst)
      (state_q == S_RD) |-> $onehot0(up_match));

endmodule
